// File: rtl/button_debounce_if.sv
// Button conditioning bus: raw pad input toward the debouncer, clean level,
// qualification status and long-press pulse back out.
interface button_debounce_if;
   logic btn_in;
   logic btn_clean;
   logic busy;
   logic long_press;

   // Master owns the raw pad signal and consumes the conditioned outputs.
   modport master (
      output btn_in,
      input  btn_clean,
      input  busy,
      input  long_press
   );

   // Slave is the debouncer itself.
   modport slave (
      input  btn_in,
      output btn_clean,
      output busy,
      output long_press
   );
endinterface

// File: rtl/button_debounce.sv
// Push-button front end: two-flop synchroniser, stability-counter debounce FSM,
// and an optional long-press pulse generator enabled by BTN_LONGPRESS_EN.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int LONG_CYCLES     = 100000000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1,
   parameter int LCNT_W          = $clog2(LONG_CYCLES) + 1
) (
   input  logic               clk,
   input  logic               reset,
   button_debounce_if.slave   bus
);

   typedef enum logic [1:0] {
      S_LOW  = 2'd0,
      S_RISE = 2'd1,
      S_HIGH = 2'd2,
      S_FALL = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   generate
      if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1 || CNT_W < 1 || LCNT_W < 1) begin : g_bad_param
         $error("button_debounce: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 1");
      end
   endgenerate

   logic [1:0]       sync_reg;
   logic             btn_sync;
   state_t           state_reg;
   state_t           state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             clean_reg;
   logic             clean_next;
   logic             busy_reg;
   logic             busy_next;

   // Only the second flop may be observed; the first is allowed to go metastable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_reg <= 2'b00;
      end else begin
         sync_reg <= {sync_reg[0], bus.btn_in};
      end
   end

   assign btn_sync = sync_reg[1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= S_LOW;
         cnt_reg   <= '0;
         clean_reg <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         clean_reg <= clean_next;
         busy_reg  <= busy_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = '0;
      case (state_reg)
         S_LOW: begin
            if (btn_sync) begin
               state_next = S_RISE;
            end
         end
         S_RISE: begin
            if (!btn_sync) begin
               state_next = S_LOW;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = S_HIGH;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         S_HIGH: begin
            if (!btn_sync) begin
               state_next = S_FALL;
            end
         end
         S_FALL: begin
            if (btn_sync) begin
               state_next = S_HIGH;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = S_LOW;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         default: begin
            state_next = S_LOW;
         end
      endcase
   end

   // Outputs are registered copies of what the next state implies, so they
   // change on the same edge as the state and never glitch.
   always_comb begin
      clean_next = (state_next == S_HIGH) || (state_next == S_FALL);
      busy_next  = (state_next == S_RISE) || (state_next == S_FALL);
   end

   assign bus.btn_clean = clean_reg;
   assign bus.busy      = busy_reg;

`ifdef BTN_LONGPRESS_EN
   localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LONG_CYCLES - 1);

   logic [LCNT_W-1:0] lcnt_reg;
   logic [LCNT_W-1:0] lcnt_next;
   logic              lp_done_reg;
   logic              lp_done_next;
   logic              long_press_reg;
   logic              long_press_next;
   logic              hold_active;

   // A release bounce (S_FALL) still counts as holding the button.
   assign hold_active = (state_reg == S_HIGH) || (state_reg == S_FALL);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lcnt_reg       <= '0;
         lp_done_reg    <= 1'b0;
         long_press_reg <= 1'b0;
      end else begin
         lcnt_reg       <= lcnt_next;
         lp_done_reg    <= lp_done_next;
         long_press_reg <= long_press_next;
      end
   end

   always_comb begin
      lcnt_next       = lcnt_reg;
      lp_done_next    = lp_done_reg;
      long_press_next = 1'b0;
      if (hold_active) begin
         if (lcnt_reg == LCNT_LAST) begin
            if (!lp_done_reg) begin
               long_press_next = 1'b1;
               lp_done_next    = 1'b1;
            end
         end else begin
            lcnt_next = lcnt_reg + LCNT_W'(1);
         end
      end
      // A fresh press or a completed release re-arms the detector.
      if ((state_reg == S_RISE && state_next == S_HIGH) || (state_next == S_LOW)) begin
         lcnt_next    = '0;
         lp_done_next = 1'b0;
      end
   end

   assign bus.long_press = long_press_reg;
`else
   assign bus.long_press = 1'b0;
`endif

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Front-end conditioning stage for raw push-button inputs; sits directly upstream of the rising-edge pulse generator and drives its button input.
- Synchronises the asynchronous pad signal, rejects contact bounce with a stability counter, and presents a clean, glitch-free level.
- One instance per physical button.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive cycles the synchronised input must hold a new value before btn_clean follows (10 ms at 100 MHz); legal range is >=1.
- LONG_CYCLES, 100000000, cycles btn_clean must stay high before long_press fires (only with BTN_LONGPRESS_EN); legal range is >=1.
- CNT_W, $clog2(DEBOUNCE_CYCLES)+1, debounce counter width (derived; do not override).
- LCNT_W, $clog2(LONG_CYCLES)+1, long-press counter width (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- btn_in  input  1  raw button pad signal; asynchronous, may bounce.
- btn_clean  output  1  debounced level; feeds the edge-detect stage.
- busy  output  1  high while a candidate transition is being qualified (S_RISE or S_FALL).
- long_press  output  1  single-cycle pulse on a long hold (BTN_LONGPRESS_EN); otherwise tied 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - sync flops, counters and state are cleared; state = S_LOW.
  - btn_clean=0, busy=0, long_press=0.
  - Reset asserted mid-qualification abandons the qualification immediately.
  - After reset releases, all outputs stay low until a full qualification completes.
- Synchroniser: two flops, sync1<=btn_in, btn_sync<=sync1. Only btn_sync is used downstream.
- FSM states: S_LOW, S_RISE, S_HIGH, S_FALL.
  - S_LOW: btn_clean=0. btn_sync=1 -> S_RISE, cnt<=0.
  - S_RISE: btn_sync=0 -> S_LOW, cnt<=0 (bounce rejected; btn_clean never toggles). btn_sync=1 and cnt==DEBOUNCE_CYCLES-1 -> S_HIGH, btn_clean<=1. Otherwise cnt<=cnt+1.
  - S_HIGH: btn_clean=1. btn_sync=0 -> S_FALL, cnt<=0.
  - S_FALL: mirror of S_RISE. btn_sync=1 -> S_HIGH (btn_clean stays 1). btn_sync=0 and cnt==DEBOUNCE_CYCLES-1 -> S_LOW, btn_clean<=0. Otherwise cnt<=cnt+1.
- Outputs are registered; busy is derived from the registered state.
- Latency: if edge N is the first edge sampling btn_in=1 (held stable), btn_clean rises after edge N+2+DEBOUNCE_CYCLES. Release latency is symmetric.
- Counter only counts in S_RISE/S_FALL, never exceeds DEBOUNCE_CYCLES-1, so it never wraps.
- Any glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no btn_clean change.
- A glitch at the exact terminal count restarts qualification from cnt=0 on the next valid sample.

Optional Feature:
- Macro: BTN_LONGPRESS_EN.
- Defined:
  - lcnt clears on entry to S_HIGH and increments each cycle in S_HIGH and S_FALL (a bounce during a hold does not reset it).
  - When lcnt reaches LONG_CYCLES-1, long_press=1 for exactly one cycle, then lcnt saturates.
  - At most one pulse per press.
  - lcnt clears on S_LOW entry and on reset.
- Undefined: long_press is constant 0, no long-press counter is synthesised, and the port remains present.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=16):
- Reset check: hold reset=0 with btn_in=1, then release -> outputs 0 during reset; btn_clean=1 exactly 6 edges after the first sampling edge; busy=1 during the 4 qualifying cycles.
- Bounce reject: btn_in 1 for 3 cycles, 0 for 2, 1 for 3, then 0 -> btn_clean stays 0 throughout; busy pulses then returns to 0.
- Clean press then release: btn_in=1 for 20 cycles, then 0 -> btn_clean rises at N+6 and falls 6 edges after the first sampled 0.
- Release bounce: from S_HIGH, btn_in 0 for 3 cycles then 1 -> btn_clean stays 1 and state returns to S_HIGH.
- Mid-operation reset: assert reset during S_RISE at cnt=2 -> immediately btn_clean=0 and busy=0; after release with btn_in=1, a full 6-edge requalification is required.
- Long press (BTN_LONGPRESS_EN): hold btn_in=1 for 40 cycles -> exactly one long_press pulse, 16 cycles after btn_clean rises. Without the macro -> long_press is always 0.
